// File: rtl/clk_36mhz_sequencer.sv
// rtl/clk_36mhz_sequencer.sv - 36 MHz domain reset sequencer and clock-enable generator
// Optional LOCK_LOSS_STICKY_EN: lock loss in RUN parks the block in FAULT until resetn.
module clk_36mhz_sequencer #(
   parameter int STABLE_CYCLES = 1024,
   parameter int CPU_DIV       = 18,
   parameter int SND_DIV       = 36
) (
   input  logic       clk_36MHz,
   input  logic       resetn,
   input  logic       pll_locked,
   output logic       sys_rst_n,
   output logic       ce_cpu,
   output logic       ce_cpu_p2,
   output logic       ce_snd,
   output logic       running,
   output logic [7:0] lock_loss_cnt
);

   localparam int SW        = $clog2(STABLE_CYCLES + 1);
   localparam int CW        = (CPU_DIV > 2) ? $clog2(CPU_DIV) : 1;
   localparam int NW        = (SND_DIV > 2) ? $clog2(SND_DIV) : 1;
   // RUN is entered on the edge where stab_cnt would become STABLE_CYCLES-1
   localparam int STAB_LAST = (STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0;

`ifdef LOCK_LOSS_STICKY_EN
   typedef enum logic [1:0] {
      S_WAIT_LOCK = 2'd0,
      S_STABILIZE = 2'd1,
      S_RUN       = 2'd2,
      S_FAULT     = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_WAIT_LOCK = 2'd0,
      S_STABILIZE = 2'd1,
      S_RUN       = 2'd2
   } state_t;
`endif

   state_t          state_q, state_d;
   logic            sync1_q, lock_s_q;
   logic [SW-1:0]   stab_q, stab_d;
   logic [CW-1:0]   cpu_q, cpu_d;
   logic [NW-1:0]   snd_q, snd_d;
   logic            run_q, run_d;
   logic            ce_cpu_q, ce_cpu_d;
   logic            ce_p2_q, ce_p2_d;
   logic            ce_snd_q, ce_snd_d;
   logic [7:0]      loss_q, loss_d;

   always_ff @(posedge clk_36MHz or negedge resetn) begin
      if (!resetn) begin
         sync1_q  <= 1'b0;
         lock_s_q <= 1'b0;
         state_q  <= S_WAIT_LOCK;
         stab_q   <= '0;
         cpu_q    <= '0;
         snd_q    <= '0;
         run_q    <= 1'b0;
         ce_cpu_q <= 1'b0;
         ce_p2_q  <= 1'b0;
         ce_snd_q <= 1'b0;
         loss_q   <= '0;
      end else begin
         sync1_q  <= pll_locked;
         lock_s_q <= sync1_q;
         state_q  <= state_d;
         stab_q   <= stab_d;
         cpu_q    <= cpu_d;
         snd_q    <= snd_d;
         run_q    <= run_d;
         ce_cpu_q <= ce_cpu_d;
         ce_p2_q  <= ce_p2_d;
         ce_snd_q <= ce_snd_d;
         loss_q   <= loss_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      stab_d   = stab_q;
      cpu_d    = '0;
      snd_d    = '0;
      run_d    = 1'b0;
      ce_cpu_d = 1'b0;
      ce_p2_d  = 1'b0;
      ce_snd_d = 1'b0;
      loss_d   = loss_q;
      case (state_q)
         S_WAIT_LOCK: begin
            stab_d = '0;
            if (lock_s_q) begin
               if (STABLE_CYCLES == 1) begin
                  state_d = S_RUN;
                  run_d   = 1'b1;
               end else begin
                  state_d = S_STABILIZE;
               end
            end
         end
         S_STABILIZE: begin
            if (!lock_s_q) begin
               state_d = S_WAIT_LOCK;
               stab_d  = '0;
            end else if (stab_q == SW'(STAB_LAST)) begin
               state_d = S_RUN;
               stab_d  = '0;
               run_d   = 1'b1;
            end else begin
               stab_d = stab_q + SW'(1);
            end
         end
         S_RUN: begin
            if (!lock_s_q) begin
               // enables stay low here, which also swallows a CE due on this edge
               loss_d = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
`ifdef LOCK_LOSS_STICKY_EN
               state_d = S_FAULT;
`else
               state_d = S_WAIT_LOCK;
`endif
            end else begin
               run_d    = 1'b1;
               cpu_d    = (cpu_q == CW'(CPU_DIV - 1)) ? '0 : cpu_q + CW'(1);
               snd_d    = (snd_q == NW'(SND_DIV - 1)) ? '0 : snd_q + NW'(1);
               ce_cpu_d = (cpu_q == CW'(CPU_DIV - 1));
               ce_p2_d  = (cpu_q == CW'(CPU_DIV / 2 - 1));
               ce_snd_d = (snd_q == NW'(SND_DIV - 1));
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase
   end

   assign sys_rst_n     = run_q;
   assign running       = run_q;
   assign ce_cpu        = ce_cpu_q;
   assign ce_cpu_p2     = ce_p2_q;
   assign ce_snd        = ce_snd_q;
   assign lock_loss_cnt = loss_q;

endmodule
